// File: rtl/mcpu_fetch.sv
// mcpu_fetch: sequential instruction fetch feeding an in-order prefetch queue.
// Define MCPU_FETCH_BYPASS_EN to forward an empty-queue response to inst in the same cycle.
module mcpu_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] nextinst,
    output logic        nextinst_valid,
    input  logic        dec_advance,
    input  logic        dec_long_imm,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   q_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] ret;
    logic [CW:0]   inflight;
    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;
    logic [31:0]   head_word;
    logic          grant;
    logic          accept;
    logic          push;
    logic          bypass;
    logic          head_valid;
    logic [1:0]    pop_cnt;
    logic [1:0]    q_pop;

    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign imem_req = ~clkrst_core_rst & ~redirect_valid
                    & (inflight < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign grant = imem_req & imem_gnt;

    assign ret = outstanding - CW'(imem_rvalid);
    assign accept = imem_rvalid & (drop_cnt == '0) & ~redirect_valid;

`ifdef MCPU_FETCH_BYPASS_EN
    assign bypass = accept & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign head_valid = (count != '0) | bypass;
    assign rd_nxt_ptr = rd_ptr + AW'(1);
    assign head_word  = bypass ? imem_rdata : q_mem[rd_ptr];

    assign inst_valid     = head_valid;
    assign inst           = head_valid ? head_word : '0;
    assign inst_pc        = head_pc;
    assign nextinst_valid = (count >= CW'(2));
    assign nextinst       = nextinst_valid ? q_mem[rd_nxt_ptr] : '0;

    // A long-immediate pair with only one word present is a bubble.
    always_comb begin
        pop_cnt = 2'd0;
        if (dec_advance && head_valid && !redirect_valid) begin
            if (!dec_long_imm) begin
                pop_cnt = 2'd1;
            end else if (nextinst_valid) begin
                pop_cnt = 2'd2;
            end
        end
    end

    // A bypassed word consumed this cycle never touches the queue.
    assign q_pop = bypass ? 2'd0 : pop_cnt;
    assign push  = accept & ~(bypass & (pop_cnt == 2'd1));

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            head_pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= ret;
            // Every word still in flight belongs to the abandoned stream.
            drop_cnt    <= ret;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            head_pc     <= head_pc + {28'd0, pop_cnt, 2'b00};
            rd_ptr      <= rd_ptr + AW'(q_pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count       <= count + CW'(push) - CW'(q_pop);
            outstanding <= ret + CW'(grant);
            if (imem_rvalid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (push) begin
            q_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
